split_bus_arbiter: RTL

- Two-master bus arbiter and split-transaction scheduler for the serial bus shared with split-capable targets.
- Grants the bus to one master at a time using round-robin.
- When a target split-acks a read, records the owning master and frees the bus for other traffic.
- When the target later raises split_req, hands the bus back to that owner by asserting split_grant together with the owner's grant.

---
 rtl/split_bus_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/split_bus_arbiter.sv
// Two-master round-robin bus arbiter with one outstanding split read.
// Ports: clk/rst (sync, active-high); m1_req/m2_req master requests;
//   target_ack/target_split_ack target pulses; split_req split return;
//   m1_grant/m2_grant/split_grant grants; split_pending/split_owner
//   outstanding split status; timeout_err one-cycle abort pulse.
module split_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  input  logic m2_req,
  input  logic target_ack,
  input  logic target_split_ack,
  input  logic split_req,
  output logic m1_grant,
  output logic m2_grant,
  output logic split_grant,
  output logic split_pending,
  output logic split_owner,
  output logic timeout_err
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SPLIT_RESUME
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          cur_q, cur_d;
  logic          sp_q, sp_d;
  logic          so_q, so_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m1g_q, m1g_d;
  logic          m2g_q, m2g_d;
  logic          sg_q, sg_d;
  logic          te_q, te_d;

  logic          m1_el;
  logic          m2_el;
  logic          pick;
  logic          cur_req;
  logic          to_hit;
  logic [CW-1:0] cnt_inc;

  // Master index encoding: 0 = m1, 1 = m2.
  always_comb begin
    m1_el   = m1_req && !(sp_q && !so_q);
    m2_el   = m2_req && !(sp_q && so_q);
    pick    = (m1_el && m2_el) ? !last_q : m2_el;
    cur_req = cur_q ? m2_req : m1_req;
    to_hit  = TO_EN && (cnt_q == CNT_MAX);
    cnt_inc = to_hit ? cnt_q : cnt_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    sp_d    = sp_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    m1g_d   = 1'b0;
    m2g_d   = 1'b0;
    sg_d    = 1'b0;
    te_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sp_q && split_req) begin
          state_d = SPLIT_RESUME;
          cnt_d   = '0;
          sg_d    = 1'b1;
          m1g_d   = !so_q;
          m2g_d   = so_q;
        end else if (m1_el || m2_el) begin
          state_d = GRANT;
          cnt_d   = '0;
          cur_d   = pick;
          last_d  = pick;
          m1g_d   = !pick;
          m2g_d   = pick;
        end
      end
      GRANT: begin
        if (target_ack) begin
          state_d = IDLE;
        end else if (target_split_ack && !sp_q) begin
          // A second split while one is outstanding is dropped.
          state_d = IDLE;
          sp_d    = 1'b1;
          so_d    = cur_q;
        end else if (!cur_req) begin
          state_d = IDLE;
        end else if (to_hit) begin
          state_d = IDLE;
          te_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          m1g_d = !cur_q;
          m2g_d = cur_q;
        end
      end
      SPLIT_RESUME: begin
        if (target_ack) begin
          state_d = IDLE;
          sp_d    = 1'b0;
        end else if (to_hit) begin
          state_d = IDLE;
          sp_d    = 1'b0;
          te_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          sg_d  = 1'b1;
          m1g_d = !so_q;
          m2g_d = so_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cur_q   <= 1'b0;
      sp_q    <= 1'b0;
      so_q    <= 1'b0;
      cnt_q   <= '0;
      m1g_q   <= 1'b0;
      m2g_q   <= 1'b0;
      sg_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      sp_q    <= sp_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      m1g_q   <= m1g_d;
      m2g_q   <= m2g_d;
      sg_q    <= sg_d;
      te_q    <= te_d;
    end
  end

  assign m1_grant      = m1g_q;
  assign m2_grant      = m2g_q;
  assign split_grant   = sg_q;
  assign split_pending = sp_q;
  assign split_owner   = so_q;
  assign timeout_err   = te_q;

endmodule
